// File: rtl/aes_job_arbiter_if.sv
// -----------------------------------------------------------------------------
// aes_job_arbiter_if
// Groups the requester handshakes and the shared AES core bus of the job
// arbiter into one bundle.
//   slave  : the arbiter (consumes requests and core results, drives grants,
//            responses and the core operands)
//   master : the environment (two requesters plus the AES core)
// Signals
//   REQ0/REQ1, KEY0/KEY1, MSG0/MSG1 : job requests and their operands
//   ACK0/ACK1                       : one-cycle grant pulses
//   RESP_VALID/RESP_ID/RESP_DATA/RESP_ERR : job completion report
//   BUSY                            : arbiter not idle
//   AES_START/AES_KEY/AES_MSG_ENC   : operands to the shared core
//   AES_DONE/AES_MSG_DEC            : core result
// -----------------------------------------------------------------------------
interface aes_job_arbiter_if;
  logic         REQ0;
  logic         REQ1;
  logic [127:0] KEY0;
  logic [127:0] KEY1;
  logic [127:0] MSG0;
  logic [127:0] MSG1;
  logic         ACK0;
  logic         ACK1;
  logic         RESP_VALID;
  logic         RESP_ID;
  logic [127:0] RESP_DATA;
  logic         RESP_ERR;
  logic         BUSY;
  logic         AES_START;
  logic [127:0] AES_KEY;
  logic [127:0] AES_MSG_ENC;
  logic         AES_DONE;
  logic [127:0] AES_MSG_DEC;

  modport slave (
    input  REQ0, REQ1, KEY0, KEY1, MSG0, MSG1, AES_DONE, AES_MSG_DEC,
    output ACK0, ACK1, RESP_VALID, RESP_ID, RESP_DATA, RESP_ERR, BUSY,
           AES_START, AES_KEY, AES_MSG_ENC
  );

  modport master (
    output REQ0, REQ1, KEY0, KEY1, MSG0, MSG1, AES_DONE, AES_MSG_DEC,
    input  ACK0, ACK1, RESP_VALID, RESP_ID, RESP_DATA, RESP_ERR, BUSY,
           AES_START, AES_KEY, AES_MSG_ENC
  );
endinterface

// File: rtl/aes_job_arbiter.sv
// -----------------------------------------------------------------------------
// aes_job_arbiter
// Shares one AES decryption core between two requesters. A round-robin
// pointer picks the winner, its key/ciphertext are captured and presented to
// the core, and the result (or a timeout error) is reported once per job.
// Ports
//   CLK   : system clock, rising edge
//   RESET : synchronous active-high reset
//   bus   : aes_job_arbiter_if.slave (requests, responses, AES core bus)
// Parameter
//   TIMEOUT : RUN cycles allowed before the job is aborted with RESP_ERR
// -----------------------------------------------------------------------------
module aes_job_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              CLK,
  input  logic              RESET,
  aes_job_arbiter_if.slave  bus
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RUN     = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t        state_r;
  logic          last_r;
  logic          owner_r;
  logic [CW-1:0] cnt_r;
  logic          ack0_r;
  logic          ack1_r;
  logic          resp_valid_r;
  logic          resp_id_r;
  logic [127:0]  resp_data_r;
  logic          resp_err_r;
  logic          busy_r;
  logic          aes_start_r;
  logic [127:0]  aes_key_r;
  logic [127:0]  aes_msg_enc_r;
  logic          grant_s;

  // Round-robin pick: a lone request wins, a tie goes to the non-LAST side.
  always_comb begin
    grant_s = 1'b0;
    if (bus.REQ0 && bus.REQ1) begin
      grant_s = ~last_r;
    end else if (bus.REQ1) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Controller FSM with all outputs registered.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r       <= ST_IDLE;
      last_r        <= 1'b1;
      owner_r       <= 1'b0;
      cnt_r         <= '0;
      ack0_r        <= 1'b0;
      ack1_r        <= 1'b0;
      resp_valid_r  <= 1'b0;
      resp_id_r     <= 1'b0;
      resp_data_r   <= 128'd0;
      resp_err_r    <= 1'b0;
      busy_r        <= 1'b0;
      aes_start_r   <= 1'b0;
      aes_key_r     <= 128'd0;
      aes_msg_enc_r <= 128'd0;
    end else begin
      // Pulse outputs default low; only the owning state raises them.
      ack0_r       <= 1'b0;
      ack1_r       <= 1'b0;
      resp_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.REQ0 || bus.REQ1) begin
            state_r       <= ST_LOAD;
            last_r        <= grant_s;
            owner_r       <= grant_s;
            aes_key_r     <= grant_s ? bus.KEY1 : bus.KEY0;
            aes_msg_enc_r <= grant_s ? bus.MSG1 : bus.MSG0;
            // ACK is set here so it is visible for exactly the LOAD cycle.
            ack0_r        <= ~grant_s;
            ack1_r        <= grant_s;
            busy_r        <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          state_r     <= ST_RUN;
          aes_start_r <= 1'b1;
          cnt_r       <= '0;
        end
        ST_RUN: begin
          // Completion is checked before the timeout so a coincident DONE wins.
          if (bus.AES_DONE) begin
            state_r      <= ST_RELEASE;
            aes_start_r  <= 1'b0;
            resp_valid_r <= 1'b1;
            resp_id_r    <= owner_r;
            resp_data_r  <= bus.AES_MSG_DEC;
            resp_err_r   <= 1'b0;
          end else if (cnt_r == CNT_LAST) begin
            state_r      <= ST_RELEASE;
            aes_start_r  <= 1'b0;
            resp_valid_r <= 1'b1;
            resp_id_r    <= owner_r;
            resp_data_r  <= 128'd0;
            resp_err_r   <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        ST_RELEASE: begin
          // Wait for the core to drop DONE so a stale result is never reused.
          if (!bus.AES_DONE) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= ST_RELEASE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          busy_r      <= 1'b0;
          aes_start_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ACK0        = ack0_r;
  assign bus.ACK1        = ack1_r;
  assign bus.RESP_VALID  = resp_valid_r;
  assign bus.RESP_ID     = resp_id_r;
  assign bus.RESP_DATA   = resp_data_r;
  assign bus.RESP_ERR    = resp_err_r;
  assign bus.BUSY        = busy_r;
  assign bus.AES_START   = aes_start_r;
  assign bus.AES_KEY     = aes_key_r;
  assign bus.AES_MSG_ENC = aes_msg_enc_r;

endmodule
